// File: rtl/executa_movimentos_pkg.sv
// Shared definitions for the movement executor: state codes, face/tipo codes and word layout.
package executa_movimentos_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ZERA       = 4'd1,
        BUSCA      = 4'd2,
        DECODIFICA = 4'd3,
        ACIONA     = 4'd4,
        AGUARDA    = 4'd5,
        ACOMODA    = 4'd6,
        PROXIMO    = 4'd7,
        FIM        = 4'd8,
        ERRO       = 4'd15
    } estado_t;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_B = 3'd3;
    localparam logic [2:0] FACE_L = 3'd4;
    localparam logic [2:0] FACE_R = 3'd5;

    localparam logic [1:0] TIPO_FIM   = 2'b00;
    localparam logic [1:0] TIPO_HOR   = 2'b01;
    localparam logic [1:0] TIPO_ANTI  = 2'b10;
    localparam logic [1:0] TIPO_DUPLO = 2'b11;

    localparam int FACE_LSB = 0;
    localparam int FACE_MSB = 2;
    localparam int TIPO_LSB = 3;
    localparam int TIPO_MSB = 4;

    function automatic logic face_valida(input logic [2:0] face);
        return face <= FACE_R;
    endfunction

endpackage

// File: rtl/executa_movimentos_if.sv
// Movement memory read port and motor driver handshake of the movement executor.
interface executa_movimentos_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        mem_dado;
    logic [ADDR_W-1:0] mem_addr;
    logic              motor_pronto;
    logic              motor_inicia;
    logic [2:0]        motor_face;
    logic              motor_sentido;

    modport master (
        input  mem_dado, motor_pronto,
        output mem_addr, motor_inicia, motor_face, motor_sentido
    );

    modport slave (
        output mem_dado, motor_pronto,
        input  mem_addr, motor_inicia, motor_face, motor_sentido
    );
endinterface

// File: rtl/executa_movimentos_contador_espera.sv
// Loadable down-counter that saturates at zero; used for the settle and watchdog timers.
module contador_espera #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega_i,
    input  logic [W-1:0] valor_i,
    input  logic         decrementa_i,
    output logic         zero_o
);
    logic [W-1:0] contagem_q, contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (carrega_i)
            contagem_d = valor_i;
        else if (decrementa_i && contagem_q != '0)
            contagem_d = contagem_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            contagem_q <= '0;
        else
            contagem_q <= contagem_d;
    end

    assign zero_o = (contagem_q == '0);
endmodule

// File: rtl/executa_movimentos.sv
// Reads movement words from RAM and drives the motor one quarter turn at a time.
// Optional TIMEOUT_MOTOR_EN adds a watchdog that sends AGUARDA to ERRO.
module executa_movimentos
    import executa_movimentos_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int ESPERA_CICLOS  = 25_000_000,
    parameter int TIMEOUT_CICLOS = 100_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    executa_movimentos_if.master bus,
    output logic                ocupado,
    output logic                pronto,
    output logic                erro,
    output logic [ADDR_W:0]     num_executados,
    output logic [3:0]          db_estado
);
    localparam int ESP_W = $clog2(ESPERA_CICLOS + 1);

    estado_t           estado_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   num_q;
    logic [2:0]        face_q;
    logic              sentido_q;
    logic [1:0]        quartos_q;

    logic [2:0] face_lida;
    logic [1:0] tipo_lido;
    logic [2:0] unused_bits;
    assign face_lida   = bus.mem_dado[FACE_MSB:FACE_LSB];
    assign tipo_lido   = bus.mem_dado[TIPO_MSB:TIPO_LSB];
    assign unused_bits = bus.mem_dado[7:5];

    // Settle timer: loaded as the motor reports completion, so ACOMODA lasts ESPERA_CICLOS cycles.
    logic             espera_carrega, espera_zero;
    logic [ESP_W-1:0] espera_valor;
    assign espera_carrega = (estado_q == ZERA) || (estado_q == AGUARDA && bus.motor_pronto);
    assign espera_valor   = (estado_q == ZERA) ? '0 : ESP_W'(ESPERA_CICLOS - 1);

    contador_espera #(.W(ESP_W)) u_espera (
        .clock        (clock),
        .reset        (reset),
        .carrega_i    (espera_carrega),
        .valor_i      (espera_valor),
        .decrementa_i (estado_q == ACOMODA),
        .zero_o       (espera_zero)
    );

`ifdef TIMEOUT_MOTOR_EN
    // Reloaded in every ACIONA; reaching zero in AGUARDA puts ERRO exactly TIMEOUT_CICLOS after ACIONA.
    localparam int WD_W = $clog2(TIMEOUT_CICLOS + 1);
    logic            wd_zero;
    logic [WD_W-1:0] wd_valor;
    assign wd_valor = (estado_q == ZERA) ? '0 : WD_W'(TIMEOUT_CICLOS - 2);

    contador_espera #(.W(WD_W)) u_watchdog (
        .clock        (clock),
        .reset        (reset),
        .carrega_i    ((estado_q == ZERA) || (estado_q == ACIONA)),
        .valor_i      (wd_valor),
        .decrementa_i (estado_q == AGUARDA),
        .zero_o       (wd_zero)
    );
`else
    localparam int unused_timeout = TIMEOUT_CICLOS;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            addr_q    <= '0;
            num_q     <= '0;
            face_q    <= '0;
            sentido_q <= 1'b0;
            quartos_q <= '0;
        end else begin
            case (estado_q)
                INICIAL: if (iniciar) estado_q <= ZERA;
                ZERA: begin
                    addr_q   <= '0;
                    num_q    <= '0;
                    estado_q <= BUSCA;
                end
                BUSCA: estado_q <= DECODIFICA;
                DECODIFICA: begin
                    if (tipo_lido == TIPO_FIM)
                        estado_q <= FIM;
                    else if (!face_valida(face_lida))
                        estado_q <= ERRO;
                    else begin
                        face_q    <= face_lida;
                        sentido_q <= (tipo_lido != TIPO_ANTI);
                        quartos_q <= (tipo_lido == TIPO_DUPLO) ? 2'd2 : 2'd1;
                        estado_q  <= ACIONA;
                    end
                end
                ACIONA: begin
                    quartos_q <= quartos_q - 2'd1;
                    estado_q  <= AGUARDA;
                end
                AGUARDA: begin
                    if (bus.motor_pronto)
                        estado_q <= ACOMODA;
`ifdef TIMEOUT_MOTOR_EN
                    else if (wd_zero)
                        estado_q <= ERRO;
`endif
                end
                ACOMODA: if (espera_zero) estado_q <= (quartos_q != 2'd0) ? ACIONA : PROXIMO;
                PROXIMO: begin
                    num_q <= num_q + 1'b1;
                    if (&addr_q)
                        estado_q <= FIM;
                    else begin
                        addr_q   <= addr_q + 1'b1;
                        estado_q <= BUSCA;
                    end
                end
                FIM:  estado_q <= INICIAL;
                ERRO: if (iniciar) estado_q <= ZERA;
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign bus.mem_addr      = addr_q;
    assign bus.motor_inicia  = (estado_q == ACIONA);
    assign bus.motor_face    = face_q;
    assign bus.motor_sentido = sentido_q;
    assign ocupado           = !(estado_q == INICIAL || estado_q == FIM || estado_q == ERRO);
    assign pronto            = (estado_q == FIM);
    assign erro              = (estado_q == ERRO);
    assign num_executados    = num_q;
    assign db_estado         = estado_q;
endmodule

// File: tb/tb_executa_movimentos.sv
// Directed bench for executa_movimentos with a synchronous RAM model and a simple motor driver model.
module tb_executa_movimentos;
    localparam int ADDR_W  = 6;
    localparam int ESPERA  = 4;
    localparam int TIMEOUT = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0;
    logic ocupado, pronto, erro;
    logic [ADDR_W:0] num_executados;
    logic [3:0] db_estado;

    executa_movimentos_if #(.ADDR_W(ADDR_W)) bus ();

    executa_movimentos #(
        .ADDR_W         (ADDR_W),
        .ESPERA_CICLOS  (ESPERA),
        .TIMEOUT_CICLOS (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .bus            (bus.master),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .erro           (erro),
        .num_executados (num_executados),
        .db_estado      (db_estado)
    );

    logic [7:0] mem [64];
    logic [7:0] memDado;
    logic motorPronto = 1'b0;
    logic motorOn = 1'b0;
    int pendente = 0;
    int assertCount = 0;
    int failCount = 0;
    int cmdCount = 0;
    int prontoCount = 0;
    int zeraCount = 0;
    logic [2:0] cmdFace [128];
    logic cmdSentido [128];

    assign bus.mem_dado     = memDado;
    assign bus.motor_pronto = motorPronto;

    always #5 clock = ~clock;

    // Synchronous RAM: one cycle from address to data.
    always @(posedge clock) memDado <= mem[bus.mem_addr];

    // Command log plus a motor that answers three cycles after each command.
    always @(negedge clock) begin
        if (bus.motor_inicia) begin
            if (cmdCount < 128) begin
                cmdFace[cmdCount]    = bus.motor_face;
                cmdSentido[cmdCount] = bus.motor_sentido;
            end
            cmdCount++;
        end
        if (pronto) prontoCount++;
        if (db_estado == 4'd1) zeraCount++;
        if (motorPronto) motorPronto = 1'b0;
        if (pendente > 0) begin
            pendente--;
            if (pendente == 0) motorPronto = 1'b1;
        end
        if (bus.motor_inicia && motorOn) pendente = 3;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observado, input logic [31:0] esperado);
        assertCount++;
        if (observado !== esperado) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observado, esperado);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] alvo, input int limite, output int ciclos);
        ciclos = -1;
        for (int i = 1; i <= limite; i++) begin
            if (ciclos < 0) begin
                @(negedge clock);
                if (db_estado == alvo) ciclos = i;
            end
        end
        if (ciclos < 0) checkOutput("timeout_estado", db_estado, alvo);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int c;
        logic [2:0] expF [4];
        logic expS [4];
        logic [2:0] f;
        expF[0] = 3'd0; expS[0] = 1'b1;
        expF[1] = 3'd2; expS[1] = 1'b0;
        expF[2] = 3'd5; expS[2] = 1'b1;
        expF[3] = 3'd5; expS[3] = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        // Reset state
        #12;
        checkOutput("rst_estado", db_estado, 0);
        checkOutput("rst_ocupado", ocupado, 0);
        checkOutput("rst_inicia", bus.motor_inicia, 0);
        checkOutput("rst_addr", bus.mem_addr, 0);
        checkOutput("rst_num", num_executados, 0);
        checkOutput("rst_pronto", pronto, 0);
        checkOutput("rst_erro", erro, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("rst_sem_cmd", cmdCount, 0);
        checkOutput("rst_inicial", db_estado, 0);

        // Four-word program: U cw, F ccw, R double, end
        mem[0] = 8'h08; mem[1] = 8'h12; mem[2] = 8'h1D; mem[3] = 8'h00;
        cmdCount = 0; prontoCount = 0; motorOn = 1'b1;
        applyStimulus();
        waitState(4'd8, 600, c);
        @(negedge clock);
        checkOutput("a_num_cmds", cmdCount, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("a_face%0d", i), cmdFace[i], expF[i]);
            checkOutput($sformatf("a_sentido%0d", i), cmdSentido[i], expS[i]);
        end
        checkOutput("a_pronto_pulsos", prontoCount, 1);
        checkOutput("a_num_exec", num_executados, 3);
        checkOutput("a_addr", bus.mem_addr, 3);
        checkOutput("a_inicial", db_estado, 0);

        // Word 0 is the end word
        mem[0] = 8'h00;
        cmdCount = 0;
        applyStimulus();
        checkOutput("b_zera", db_estado, 1);
        waitState(4'd8, 20, c);
        checkOutput("b_latencia_fim", c, 3);
        @(negedge clock);
        checkOutput("b_sem_cmd", cmdCount, 0);
        checkOutput("b_num_exec", num_executados, 0);

        // Invalid face in word 1
        mem[0] = 8'h08; mem[1] = 8'h0F;
        cmdCount = 0;
        applyStimulus();
        waitState(4'd15, 200, c);
        @(negedge clock);
        checkOutput("c_erro", erro, 1);
        checkOutput("c_ocupado", ocupado, 0);
        checkOutput("c_num_cmds", cmdCount, 1);
        checkOutput("c_num_exec", num_executados, 1);
        mem[0] = 8'h00;
        applyStimulus();
        checkOutput("c_zera", db_estado, 1);
        waitState(4'd8, 20, c);
        checkOutput("c_reinicio_lat", c, 3);
        checkOutput("c_reinicio_addr", bus.mem_addr, 0);

        // Motor never answers
        mem[0] = 8'h08; mem[1] = 8'h00;
        motorOn = 1'b0; cmdCount = 0;
        applyStimulus();
        waitState(4'd4, 10, c);
`ifdef TIMEOUT_MOTOR_EN
        waitState(4'd15, 40, c);
        checkOutput("d_timeout_ciclos", c, TIMEOUT);
        checkOutput("d_erro", erro, 1);
`else
        repeat (40) @(negedge clock);
        checkOutput("d_aguarda", db_estado, 5);
        checkOutput("d_sem_erro", erro, 0);
        checkOutput("d_ocupado", ocupado, 1);
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Asynchronous reset in the middle of a turn
        mem[0] = 8'h0D; mem[1] = 8'h00;
        motorOn = 1'b0;
        applyStimulus();
        waitState(4'd5, 10, c);
        checkOutput("e_face_antes", bus.motor_face, 5);
        checkOutput("e_sentido_antes", bus.motor_sentido, 1);
        reset = 1'b0;
        #1;
        checkOutput("e_estado", db_estado, 0);
        checkOutput("e_face", bus.motor_face, 0);
        checkOutput("e_sentido", bus.motor_sentido, 0);
        checkOutput("e_ocupado", ocupado, 0);
        checkOutput("e_inicia", bus.motor_inicia, 0);
        @(negedge clock);
        reset = 1'b1;
        cmdCount = 0;
        repeat (6) @(negedge clock);
        checkOutput("e_sem_cmd", cmdCount, 0);
        checkOutput("e_inicial", db_estado, 0);

        // iniciar toggling while busy must not restart
        mem[0] = 8'h1D; mem[1] = 8'h00;
        motorOn = 1'b1; cmdCount = 0; zeraCount = 0;
        applyStimulus();
        repeat (10) begin
            @(negedge clock);
            iniciar = ~iniciar;
        end
        iniciar = 1'b0;
        waitState(4'd8, 200, c);
        @(negedge clock);
        checkOutput("e_zera_unica", zeraCount, 1);
        checkOutput("e_num_cmds", cmdCount, 2);
        checkOutput("e_num_exec", num_executados, 1);

        // Full memory of moves
        for (int i = 0; i < 64; i++) begin
            f = 3'(i % 6);
            mem[i] = {3'b000, 2'b01, f};
        end
        cmdCount = 0;
        applyStimulus();
        waitState(4'd8, 3000, c);
        checkOutput("f_addr", bus.mem_addr, 63);
        checkOutput("f_num_exec", num_executados, 64);
        @(negedge clock);
        checkOutput("f_num_cmds", cmdCount, 64);
        checkOutput("f_ultima_face", cmdFace[63], 3);
        checkOutput("f_num_mantido", num_executados, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/executa_movimentos.md
EXECUTA_MOVIMENTOS -- requirements
Module: executa_movimentos

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, movement memory address width (64 moves).
REQ-002 SHALL have parameter ESPERA_CICLOS, default 25_000_000, settle cycles after each quarter turn.
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 100_000_000, motor watchdog limit.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port iniciar  in  1  start request; sampled only in INICIAL or ERRO.
REQ-007 SHALL have port mem_dado  in  8  movement word: [2:0] face (0..5 = U,D,F,B,L,R), [4:3] tipo (00 end, 01 clockwise, 10 counter-clockwise, 11 double), [7:5] ignored.
REQ-008 SHALL have port mem_addr  out  ADDR_W  movement memory read address; synchronous RAM, 1-cycle latency.
REQ-009 SHALL have port motor_pronto  in  1  motor driver completion, level or pulse.
REQ-010 SHALL have port motor_inicia  out  1  one-cycle quarter-turn command.
REQ-011 SHALL have port motor_face  out  3  face for the current command.
REQ-012 SHALL have port motor_sentido  out  1  1 = clockwise, 0 = counter-clockwise.
REQ-013 SHALL have port ocupado  out  1  high in every state except INICIAL, FIM and ERRO.
REQ-014 SHALL have port pronto  out  1  one-cycle pulse on sequence completion.
REQ-015 SHALL have port erro  out  1  high while in ERRO.
REQ-016 SHALL have port num_executados  out  ADDR_W+1  count of completed movement words.
REQ-017 SHALL have port db_estado  out  4  current state code.

Function
REQ-018 States and codes SHALL be: INICIAL 0, ZERA 1, BUSCA 2, DECODIFICA 3, ACIONA 4, AGUARDA 5, ACOMODA 6, PROXIMO 7, FIM 8, ERRO 15. Unused codes go to INICIAL.
REQ-019 INICIAL→ZERA when iniciar=1. In ZERA, mem_addr, num_executados and the timers SHALL clear; ZERA→BUSCA.
REQ-020 BUSCA SHALL last exactly one cycle to cover RAM latency; BUSCA→DECODIFICA.
REQ-021 DECODIFICA SHALL go to FIM if tipo=00, otherwise to ERRO if face≥6.
REQ-022 Otherwise DECODIFICA SHALL latch face, latch sentido (tipo≠10), load quartos=2 if tipo=11 else 1, and go to ACIONA.
REQ-023 ACIONA SHALL assert motor_inicia for exactly one cycle, decrement quartos, and go to AGUARDA. motor_pronto SHALL NOT be sampled in ACIONA.
REQ-024 AGUARDA→ACOMODA on motor_pronto=1. motor_face and motor_sentido SHALL stay stable from ACIONA through AGUARDA.
REQ-025 ACOMODA SHALL wait exactly ESPERA_CICLOS cycles. It then goes to ACIONA if quartos≠0, else to PROXIMO.
REQ-026 PROXIMO SHALL increment num_executados. If mem_addr = all-ones it goes to FIM with mem_addr unchanged; otherwise mem_addr increments and the state goes to BUSCA.
REQ-027 FIM SHALL assert pronto for one cycle and go to INICIAL. num_executados SHALL hold its value until the next ZERA.
REQ-028 ERRO SHALL hold erro=1 and go to ZERA on iniciar=1.
REQ-029 iniciar SHALL be ignored while ocupado=1.

Reset
REQ-030 While reset=0, state SHALL be INICIAL and every output SHALL be 0, including mem_addr, num_executados and db_estado. This takes effect asynchronously, including mid-turn.
REQ-031 After reset deasserts, no motor command SHALL issue until a new iniciar.

Configuration
REQ-032 With TIMEOUT_MOTOR_EN defined, AGUARDA SHALL go to ERRO when TIMEOUT_CICLOS cycles elapse without motor_pronto. The count SHALL restart at each ACIONA.
REQ-033 Without TIMEOUT_MOTOR_EN, AGUARDA SHALL wait indefinitely and no watchdog counter SHALL be synthesized.

Structure
REQ-034 Package executa_movimentos_pkg SHALL hold the state codes, face codes (FACE_U..FACE_R), tipo codes (TIPO_FIM, TIPO_HOR, TIPO_ANTI, TIPO_DUPLO) and the word field positions.
REQ-035 A sub-module contador_espera (loadable down-counter with a zero flag) SHALL implement the settle timer and the watchdog timer.

Verification
REQ-036 Bench runs with ESPERA_CICLOS=4 and TIMEOUT_CICLOS=20. Memory holds {U cw, F ccw, R double, end}; start with iniciar. Required: 4 motor_inicia pulses with face/sentido (0,1),(2,0),(5,1),(5,1); pronto pulses once; num_executados=3.
REQ-037 Word 0 is an end word. Required: FIM reached 3 cycles after ZERA, with no motor_inicia and num_executados=0.
REQ-038 Word 1 has face=7. Required: erro=1 after the first move completes; a later iniciar restarts at address 0.
REQ-039 With TIMEOUT_MOTOR_EN, motor_pronto is held at 0. Required: ERRO 20 cycles after ACIONA. Without the macro, the state stays AGUARDA.
REQ-040 reset=0 is pulsed during AGUARDA. Required: all outputs 0 immediately and state INICIAL; iniciar pulses while ocupado=1 cause no restart.
REQ-041 All 64 words are non-end. Required: 64 moves execute, then FIM with mem_addr=63 and num_executados=64.
